// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// operand width, op encodings, FSM states and small arithmetic helpers.
package muldiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

    // Magnitude of a signed operand; 0x80000000 maps onto itself, read as unsigned.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
        logic [WIDTH-1:0] r;
        if (is_signed && v[WIDTH-1]) begin
            r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
        logic [WIDTH-1:0] r;
        if (neg) begin
            r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v,
                                                         input logic               neg);
        logic [2*WIDTH-1:0] r;
        if (neg) begin
            r = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply (shift-add) or restoring divide.
// Accumulator layout: multiply {carry, hi, lo}, divide {remainder[W:0], quotient[W-1:0]}.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic [2*WIDTH:0] acc_i,
    input  logic [WIDTH-1:0] opnd_i,
    input  logic             div_i,
    output logic [2*WIDTH:0] acc_o,
    output logic             q_bit_o
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH+1:0] diff_s;
    logic [WIDTH:0]   rem_nxt_s;
    logic [WIDTH-1:0] addend_s;

    // Datapath for a single multiply or divide step.
    always_comb begin
        addend_s  = acc_i[0] ? opnd_i : {WIDTH{1'b0}};
        sum_s     = acc_i[2*WIDTH:WIDTH] + {1'b0, addend_s};
        shift_s   = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        diff_s    = {1'b0, shift_s} - {2'b00, opnd_i};
        rem_nxt_s = shift_s;
        if (div_i) begin
            // A non-negative trial difference means the divisor fits: keep it, quotient bit 1.
            q_bit_o = ~diff_s[WIDTH+1];
            if (q_bit_o) begin
                rem_nxt_s = diff_s[WIDTH:0];
            end else begin
                rem_nxt_s = shift_s;
            end
            acc_o = {rem_nxt_s, acc_i[WIDTH-2:0], 1'b0};
        end else begin
            q_bit_o = 1'b0;
            acc_o   = {1'b0, sum_s, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the 32-step multiply/divide unit in EX: holds the front of
// the pipeline while iterating, applies sign correction and commits HI/LO.
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             EX_start_i,
    input  logic [1:0]       EX_op_i,
    input  logic [WIDTH-1:0] EX_rs_data_i,
    input  logic [WIDTH-1:0] EX_rt_data_i,
    input  logic             MEM_pc_select_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2*WIDTH:0] acc_q;
    logic [WIDTH-1:0] opnd_q;
    logic             div_q;
    logic             neg_res_q;
    logic             neg_rem_q;
    logic             dz_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [2*WIDTH:0]   acc_step_s;
    logic [2*WIDTH:0]   acc_d;
    logic               q_bit_s;
    logic               is_div_s;
    logic               is_signed_s;
    logic [WIDTH-1:0]   rs_abs_s;
    logic [WIDTH-1:0]   rt_abs_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;

    muldiv_step u_step (
        .acc_i   (acc_q),
        .opnd_i  (opnd_q),
        .div_i   (div_q),
        .acc_o   (acc_step_s),
        .q_bit_o (q_bit_s)
    );

    // Decode of the incoming instruction and operand magnitudes.
    always_comb begin
        is_div_s    = (EX_op_i == OP_DIV)  || (EX_op_i == OP_DIVU);
        is_signed_s = (EX_op_i == OP_MULT) || (EX_op_i == OP_DIV);
        rs_abs_s    = abs_val(EX_rs_data_i, is_signed_s);
        rt_abs_s    = abs_val(EX_rt_data_i, is_signed_s);
        acc_d       = acc_step_s | {{(2*WIDTH){1'b0}}, q_bit_s};
    end

    // Sign-corrected HI/LO values committed in FIX.
    always_comb begin
        prod_s = cond_neg_wide(acc_q[2*WIDTH-1:0], neg_res_q);
        if (div_q) begin
            // On divide-by-zero the remainder is |rs|; restoring the dividend sign yields rs itself.
            hi_d = cond_neg(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
            if (dz_q) begin
                lo_d = {WIDTH{1'b1}};
            end else begin
                lo_d = cond_neg(acc_q[WIDTH-1:0], neg_res_q);
            end
        end else begin
            hi_d = prod_s[2*WIDTH-1:WIDTH];
            lo_d = prod_s[WIDTH-1:0];
        end
    end

    // Pipeline hold and completion strobe, decoded from state and inputs.
    always_comb begin
        stall_o = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                stall_o = EX_start_i && !MEM_pc_select_i;
                done_o  = 1'b0;
            end
            CALC: begin
                stall_o = !MEM_pc_select_i;
                done_o  = 1'b0;
            end
            FIX: begin
                stall_o = 1'b0;
                done_o  = !MEM_pc_select_i;
            end
            default: begin
                stall_o = 1'b0;
                done_o  = 1'b0;
            end
        endcase
    end

    // Sequencer state, iteration registers and the HI/LO result registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            acc_q     <= {(2*WIDTH+1){1'b0}};
            opnd_q    <= {WIDTH{1'b0}};
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
        end else if (MEM_pc_select_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (EX_start_i) begin
                        state_q   <= CALC;
                        cnt_q     <= {CNT_W{1'b0}};
                        div_q     <= is_div_s;
                        neg_res_q <= is_signed_s && (EX_rs_data_i[WIDTH-1] ^ EX_rt_data_i[WIDTH-1]);
                        neg_rem_q <= is_signed_s && EX_rs_data_i[WIDTH-1];
                        dz_q      <= is_div_s && (EX_rt_data_i == {WIDTH{1'b0}});
                        if (is_div_s) begin
                            acc_q  <= {{(WIDTH+1){1'b0}}, rs_abs_s};
                            opnd_q <= rt_abs_s;
                        end else begin
                            acc_q  <= {{(WIDTH+1){1'b0}}, rt_abs_s};
                            opnd_q <= rs_abs_s;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_q <= FIX;
                    end else begin
                        state_q <= CALC;
                    end
                end
                FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed scoreboard bench for muldiv_ctrl: cycle-exact stall/done checks,
// HI/LO results against hand-computed values, flush and reset aborts.
module tb_muldiv_ctrl;

    logic        clk;
    logic        rst;
    logic        ex_start;
    logic [1:0]  ex_op;
    logic [31:0] ex_rs;
    logic [31:0] ex_rt;
    logic        pc_sel;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          tests;
    int          fails;
    logic [63:0] sb_q[$];
    logic [63:0] model;
    logic        pending;

    muldiv_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .EX_start_i      (ex_start),
        .EX_op_i         (ex_op),
        .EX_rs_data_i    (ex_rs),
        .EX_rt_data_i    (ex_rt),
        .MEM_pc_select_i (pc_sel),
        .stall_o         (stall),
        .done_o          (done),
        .hi_o            (hi),
        .lo_o            (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Retire the result whose done pulse was seen in the previous cycle.
    task automatic sb_pop();
        if (pending) begin
            pending = 1'b0;
            check("sb_nonempty", (sb_q.size() != 0) ? 64'd1 : 64'd0, 64'd1);
            if (sb_q.size() != 0) model = sb_q.pop_front();
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [63:0] exp, input string tag);
        ex_op = op; ex_rs = rs; ex_rt = rt; ex_start = 1'b1;
        sb_q.push_back(exp);
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            sb_pop();
            check({tag, "_hilo"}, {hi, lo}, model);
            check({tag, "_stall"}, {63'd0, stall}, (c <= 32) ? 64'd1 : 64'd0);
            check({tag, "_done"}, {63'd0, done}, (c == 33) ? 64'd1 : 64'd0);
            if (done) pending = 1'b1;
            @(posedge clk); #1;
        end
        ex_start = 1'b0;
        check({tag, "_done_seen"}, {63'd0, pending}, 64'd1);
    endtask

    task automatic run_abort(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                             input int ac, input bit use_rst, input string tag);
        ex_op = op; ex_rs = rs; ex_rt = rt; ex_start = 1'b1;
        for (int c = 0; c <= ac; c++) begin
            if (c == ac) begin
                if (use_rst) rst = 1'b1;
                else         pc_sel = 1'b1;
            end
            @(negedge clk);
            sb_pop();
            check({tag, "_hilo"}, {hi, lo}, model);
            check({tag, "_stall"}, {63'd0, stall}, (use_rst || c < ac) ? 64'd1 : 64'd0);
            check({tag, "_done"}, {63'd0, done}, 64'd0);
            @(posedge clk); #1;
        end
        rst = 1'b0; pc_sel = 1'b0; ex_start = 1'b0;
        if (use_rst) model = 64'd0;
    endtask

    task automatic drain();
        @(negedge clk);
        sb_pop();
        check("drain_hilo", {hi, lo}, model);
        check("drain_stall", {63'd0, stall}, 64'd0);
        check("drain_done", {63'd0, done}, 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        tests = 0; fails = 0; pending = 1'b0; model = 64'd0;
        rst = 1'b1; ex_start = 1'b0; ex_op = 2'b00; ex_rs = 32'd0; ex_rt = 32'd0; pc_sel = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_stall", {63'd0, stall}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        @(posedge clk); #1;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max");
        drain();
        run_op(2'b00, 32'hFFFF_FFF9, 32'd3,         64'hFFFF_FFFF_FFFF_FFEB, "mult_neg");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, "div_neg");
        run_op(2'b11, 32'd100,       32'd0,         64'h0000_0064_FFFF_FFFF, "divu_zero");
        run_op(2'b11, 32'd100,       32'd7,         64'h0000_0002_0000_000E, "divu_100_7");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_min");
        run_op(2'b10, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, "div_negdiv");
        run_op(2'b10, 32'hFFFF_FF9C, 32'd0,         64'hFFFF_FF9C_FFFF_FFFF, "div_zero_neg");
        run_op(2'b00, 32'h8000_0000, 32'd2,         64'hFFFF_FFFF_0000_0000, "mult_min");

        run_abort(2'b00, 32'd5, 32'd6, 10, 1'b0, "flush_calc");
        run_abort(2'b11, 32'd1, 32'd1, 0,  1'b0, "flush_idle");
        run_abort(2'b10, 32'd9, 32'd2, 33, 1'b0, "flush_fix");
        run_op(2'b01, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780, "multu_after_flush");

        run_abort(2'b10, 32'd1000, 32'd3, 20, 1'b1, "rst_div");
        run_op(2'b11, 32'd1000,       32'd3,         64'h0000_0001_0000_014D, "divu_b2b_1");
        run_op(2'b11, 32'hFFFF_FFFF,  32'h0000_0010, 64'h0000_000F_0FFF_FFFF, "divu_b2b_2");
        drain();

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for an iterative 32-cycle multiply/divide unit in the EX stage of the 5-stage pipeline. It accepts MULT/MULTU/DIV/DIVU from EX, stalls the front of the pipeline while it iterates, and commits the HI/LO registers. It runs alongside the combinational hazard logic: its stall is ORed into PC-write, IF/ID and ID/EX hold. A taken branch in MEM aborts it.

## Interface
- WIDTH, 32, operand width; HI/LO are WIDTH bits each.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- EX_start_i  in  1  valid mul/div instruction currently in EX.
- EX_op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- EX_rs_data_i  in  WIDTH  multiplicand / dividend.
- EX_rt_data_i  in  WIDTH  multiplier / divisor.
- MEM_pc_select_i  in  1  taken branch in MEM; flushes EX and aborts the operation.
- stall_o  out  1  hold PC, IF/ID and ID/EX; EX instruction stays put.
- done_o  out  1  one-cycle pulse; HI/LO written at the end of this cycle.
- hi_o  out  WIDTH  HI register (remainder / product upper half).
- lo_o  out  WIDTH  LO register (quotient / product lower half).

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - EX_start_i & !MEM_pc_select_i: latch op, |rs|, |rt| (for MULT/DIV), sign flags; clear counter; go to CALC.
  - Otherwise stay in IDLE.
- CALC: one radix-2 step per cycle, counter 0..WIDTH-1.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring; remainder WIDTH+1 bits, quotient shifts in from the LSB.
  - Go to FIX after the step with counter == WIDTH-1.
- FIX: apply sign correction, write HI/LO, pulse done_o, return to IDLE unconditionally. EX_start_i still high for the same instruction is not re-accepted in FIX.
- Sign rules:
  - MULT: negate the 64-bit product if operand signs differ.
  - DIV: negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Unsigned ops: no correction.
  - Abs of 0x80000000 is taken as unsigned 0x80000000.
- Divide by zero (rt == 0, any DIV op): still 34 cycles; HI = rs unmodified, LO = 0xFFFFFFFF, no sign fix.
- MEM_pc_select_i in any state: next state IDLE, HI/LO unchanged, no done_o.
- stall_o = (IDLE & EX_start_i & !MEM_pc_select_i) | (CALC & !MEM_pc_select_i).
- stall_o is low in FIX, so the instruction leaves EX at the end of FIX.
- Reset: state IDLE, counter 0, hi_o = lo_o = 0, done_o = 0, stall_o = 0; in-flight operation discarded.
- Reset has priority over flush; flush has priority over start.

## Timing
- Start seen in IDLE at cycle N: stall_o high in cycle N (combinational).
- CALC occupies N+1..N+32; FIX at N+33 with done_o = 1 and stall_o = 0.
- hi_o/lo_o show the new values from N+34. Total EX occupancy is 34 cycles.
- Back-to-back ops: the second is accepted at N+34 (IDLE) at the earliest.
- Flush at cycle M (N ≤ M ≤ N+33): stall_o low in M, IDLE at M+1. Flush in FIX suppresses done_o and the HI/LO write.
- hi_o/lo_o are registered outputs; stall_o and done_o are decoded from state plus inputs.

## Structure
- Package muldiv_pkg:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU
  - state enum (IDLE/CALC/FIX)
  - ITER = WIDTH, CNT_W = $clog2(WIDTH)
- Sub-module muldiv_step: combinational single iteration. Inputs: accumulator/remainder, operand, mode. Outputs: next accumulator and quotient bit. The controller holds all registers.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> stall_o high in cycles 0..32, done_o at cycle 33, HI=0xFFFFFFFE, LO=0x00000001 visible at cycle 34.
- MULT -7 × 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=100.
- DIVU 100 / 7 -> LO=14, HI=2.
- DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- MULT 5 × 6 with MEM_pc_select_i at cycle 10 -> stall_o low in cycle 10, IDLE at 11, no done_o, HI/LO keep prior values.
- Start together with MEM_pc_select_i in IDLE -> not accepted, stall_o stays 0.
- rst_i at cycle 20 of a DIV -> IDLE next cycle, HI=LO=0.
- Two back-to-back DIVU ops -> second accepted at cycle 34, done_o pulses at 33 and 67.
